// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle MIPS conditional-branch controller with delay-slot wait and redirect handshake
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        iValid,
    output logic        oReady,
    input  logic [2:0]  iOp,
    input  logic [31:0] iPc,
    input  logic [15:0] iImm,
    input  logic [31:0] iRs,
    input  logic [31:0] iRt,
    input  logic        iSlotDone,
    input  logic        iFlush,
    output logic        oRedirValid,
    input  logic        iRedirReady,
    output logic [31:0] oRedirPc,
    output logic        oTaken,
    output logic        oBusy,
    output logic [15:0] oBrCnt,
    output logic [15:0] oTakenCnt
);
    typedef enum logic [1:0] {IDLE, EVAL, DSLOT, REDIR} state_t;
    state_t      state;
    logic [2:0]  op;
    logic [31:0] pc, rs, rt, target;
    logic [15:0] imm;
    logic        cond;
    assign target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    // branch condition on the latched operands; illegal opcodes are never taken
    always_comb begin
        cond = op == 3'd0 ? rs == rt :
               op == 3'd1 ? rs != rt :
               op == 3'd2 ? $signed(rs) <= 32'sd0 :
               op == 3'd3 ? $signed(rs) >  32'sd0 :
               op == 3'd4 ? $signed(rs) <  32'sd0 :
               op == 3'd5 ? $signed(rs) >= 32'sd0 : 1'b0;
    end
    // FSM with registered handshake/status outputs; flush always returns to IDLE without a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            oReady      <= 1'b1;
            oBusy       <= 1'b0;
            oRedirValid <= 1'b0;
            oTaken      <= 1'b0;
            oRedirPc    <= 32'd0;
            oBrCnt      <= 16'd0;
            oTakenCnt   <= 16'd0;
        end else begin
            case (state)
                IDLE: if (iValid && !iFlush) begin
                    op     <= iOp;
                    pc     <= iPc;
                    imm    <= iImm;
                    rs     <= iRs;
                    rt     <= iRt;
                    state  <= EVAL;
                    oReady <= 1'b0;
                    oBusy  <= 1'b1;
                end
                EVAL: if (iFlush) begin
                    state  <= IDLE;
                    oReady <= 1'b1;
                    oBusy  <= 1'b0;
                end else begin
                    oTaken    <= cond;
                    oRedirPc  <= target;
                    oBrCnt    <= oBrCnt + {15'd0, ~&oBrCnt};
                    oTakenCnt <= oTakenCnt + {15'd0, cond & ~&oTakenCnt};
                    state     <= cond ? DSLOT : IDLE;
                    oReady    <= !cond;
                    oBusy     <= cond;
                end
                DSLOT: if (iFlush) begin
                    state  <= IDLE;
                    oReady <= 1'b1;
                    oBusy  <= 1'b0;
                end else if (iSlotDone) begin
                    state       <= REDIR;
                    oRedirValid <= 1'b1;
                end
                REDIR: if (iFlush || iRedirReady) begin
                    state       <= IDLE;
                    oRedirValid <= 1'b0;
                    oReady      <= 1'b1;
                    oBusy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors with a redirect scoreboard for branch_ctrl
module tb_branch_ctrl;
    logic        clk, rst, iValid, oReady, iSlotDone, iFlush, oRedirValid, iRedirReady, oTaken, oBusy;
    logic [2:0]  iOp;
    logic [31:0] iPc, iRs, iRt, oRedirPc;
    logic [15:0] iImm, oBrCnt, oTakenCnt;
    int          tests = 0, fails = 0;
    logic [15:0] exp_br = 0, exp_tk = 0;
    logic [31:0] sb[$];
    logic        hold_q = 1'b0;
    logic [31:0] pc_q = 32'd0;

    branch_ctrl dut (
        .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady), .iOp(iOp), .iPc(iPc), .iImm(iImm),
        .iRs(iRs), .iRt(iRt), .iSlotDone(iSlotDone), .iFlush(iFlush), .oRedirValid(oRedirValid),
        .iRedirReady(iRedirReady), .oRedirPc(oRedirPc), .oTaken(oTaken), .oBusy(oBusy),
        .oBrCnt(oBrCnt), .oTakenCnt(oTakenCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completed redirect must match the oldest expected target,
    // and a pending redirect must hold its address steady.
    always @(negedge clk) begin
        if (hold_q && oRedirValid) check("redir_pc_stable", oRedirPc, pc_q);
        if (oRedirValid && iRedirReady && !iFlush && !rst) begin
            if (sb.size() == 0) check("unexpected_redir", oRedirPc, 32'hDEADBEEF);
            else check("redir_pc", oRedirPc, sb.pop_front());
        end
        hold_q = oRedirValid && !iRedirReady && !iFlush && !rst;
        pc_q = oRedirPc;
    end

    // Wait for oReady (bounded), present one branch, return in its EVAL cycle.
    task automatic start(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        int n = 0;
        while (!oReady && n < 20) begin
            step;
            n++;
        end
        if (!oReady) check("ready_wait", oReady, 1);
        iOp = op; iPc = pc; iImm = imm; iRs = rs; iRt = rt; iValid = 1'b1;
        step;
        iValid = 1'b0;
        check("eval_busy", {oBusy, oReady}, 2'b10);
    endtask

    // Called in the cycle after EVAL: model counters and compare status outputs.
    task automatic eval_counts(input bit tk);
        exp_br = exp_br == 16'hFFFF ? exp_br : exp_br + 16'd1;
        if (tk) exp_tk = exp_tk == 16'hFFFF ? exp_tk : exp_tk + 16'd1;
        check("taken", oTaken, tk);
        check("br_cnt", oBrCnt, exp_br);
        check("taken_cnt", oTakenCnt, exp_tk);
    endtask

    // Full branch with slot done and fetch ready already high.
    task automatic br(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt, input bit tk, input logic [31:0] tgt);
        if (tk) sb.push_back(tgt);
        start(op, pc, imm, rs, rt);
        step;
        eval_counts(tk);
        if (tk) begin
            check("target", oRedirPc, tgt);
            check("dslot_ready", oReady, 0);
            step;
            check("redir_valid", oRedirValid, 1);
            step;
            check("redir_one_cycle", oRedirValid, 0);
        end else check("redir_none", oRedirValid, 0);
        check("ready_back", {oReady, oBusy}, 2'b10);
    endtask

    initial begin
        rst = 1'b1; iValid = 0; iOp = 0; iPc = 0; iImm = 0; iRs = 0; iRt = 0;
        iSlotDone = 0; iFlush = 0; iRedirReady = 0;
        step; step;
        rst = 1'b0;
        step;
        check("reset_ready_busy", {oReady, oBusy, oRedirValid, oTaken}, 4'b1000);
        check("reset_pc", oRedirPc, 0);
        check("reset_cnts", {oBrCnt, oTakenCnt}, 0);

        iSlotDone = 1; iRedirReady = 1;
        br(3'd0, 32'h00400000, 16'h0010, 5, 5, 1, 32'h00400044);
        br(3'd1, 0, 0, 7, 7, 0, 0);
        br(3'd5, 32'h00001000, 16'hFFFF, 0, 0, 1, 32'h00001000);
        br(3'd3, 32'hFFFFFFFC, 16'h0001, 1, 0, 1, 32'h00000004);
        br(3'd2, 0, 0, 32'hFFFFFFFF, 0, 1, 4);
        br(3'd2, 0, 0, 0, 0, 1, 4);
        br(3'd2, 0, 0, 1, 32'hFFFFFFFF, 0, 0);
        br(3'd3, 0, 0, 0, 5, 0, 0);
        br(3'd4, 0, 0, 32'h80000000, 0, 1, 4);
        br(3'd4, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        br(3'd5, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        br(3'd0, 0, 0, 1, 2, 0, 0);
        br(3'd1, 0, 16'h8000, 1, 2, 1, 32'hFFFE0004);
        br(3'd6, 0, 0, 0, 0, 0, 0);
        br(3'd7, 0, 0, 5, 5, 0, 0);

        // Early slot pulse in EVAL is ignored; slot done 3 cycles late; fetch stalls 5 cycles.
        iSlotDone = 0; iRedirReady = 0;
        sb.push_back(32'h0000010C);
        start(3'd0, 32'h100, 16'h0002, 9, 9);
        iSlotDone = 1;
        step;
        iSlotDone = 0;
        eval_counts(1);
        check("dslot_no_redir", oRedirValid, 0);
        for (int i = 0; i < 3; i++) begin
            step;
            check("dslot_wait", {oRedirValid, oBusy}, 2'b01);
        end
        iSlotDone = 1;
        step;
        iSlotDone = 0;
        check("redir_after_slot", oRedirValid, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", oRedirValid, 1);
            check("stall_pc", oRedirPc, 32'h0000010C);
            step;
        end
        iRedirReady = 1;
        step;
        check("stall_done", {oRedirValid, oReady, oBusy}, 3'b010);

        // Flush while waiting for the delay slot.
        start(3'd0, 32'h200, 0, 3, 3);
        step;
        eval_counts(1);
        iFlush = 1;
        step;
        iFlush = 0;
        check("flush_dslot_idle", {oRedirValid, oReady, oBusy}, 3'b010);
        check("flush_dslot_tkcnt", oTakenCnt, exp_tk);
        step;
        check("flush_dslot_noredir", oRedirValid, 0);

        // Flush in REDIR wins over a simultaneous ready.
        iSlotDone = 1; iRedirReady = 0;
        start(3'd1, 0, 0, 1, 2);
        step;
        eval_counts(1);
        step;
        check("pre_flush_redir", oRedirValid, 1);
        iFlush = 1; iRedirReady = 1;
        step;
        iFlush = 0;
        check("flush_redir_idle", {oRedirValid, oReady, oBusy}, 3'b010);
        check("flush_redir_tkcnt", oTakenCnt, exp_tk);

        // Flush in EVAL drops the counter update.
        start(3'd0, 0, 0, 1, 1);
        iFlush = 1;
        step;
        iFlush = 0;
        check("flush_eval_idle", {oRedirValid, oReady, oBusy}, 3'b010);
        check("flush_eval_cnts", {oBrCnt, oTakenCnt}, {exp_br, exp_tk});

        // Flush in IDLE blocks acceptance.
        iOp = 0; iRs = 1; iRt = 1; iValid = 1; iFlush = 1;
        step;
        iValid = 0; iFlush = 0;
        check("flush_idle_reject", {oReady, oBusy}, 2'b10);
        step;
        check("flush_idle_cnt", oBrCnt, exp_br);

        // Reset mid-redirect.
        iRedirReady = 0;
        start(3'd0, 32'h300, 0, 4, 4);
        step;
        eval_counts(1);
        step;
        check("pre_rst_redir", oRedirValid, 1);
        rst = 1;
        step;
        rst = 0;
        check("rst_flags", {oReady, oBusy, oRedirValid, oTaken}, 4'b1000);
        check("rst_pc", oRedirPc, 0);
        check("rst_cnts", {oBrCnt, oTakenCnt}, 0);
        exp_br = 0; exp_tk = 0;
        iRedirReady = 1;

        // Saturation: preload the branch counter just below its limit rather than issuing 65k branches.
        force dut.oBrCnt = 16'hFFFE;
        start(3'd1, 0, 0, 1, 1);
        step;
        release dut.oBrCnt;
        for (int i = 0; i < 2; i++) begin
            start(3'd1, 0, 0, 1, 1);
            step;
        end
        check("br_cnt_sat", oBrCnt, 16'hFFFF);
        exp_br = 16'hFFFF;
        br(3'd1, 0, 0, 2, 2, 0, 0);

        step; step;
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Multi-cycle conditional-branch controller for the MIPS datapath. It accepts one branch from decode and evaluates the condition on the register operands. It computes the target as PC+4 plus the sign-extended, word-shifted 16-bit offset, waits for the delay-slot instruction to issue, then drives a valid/ready redirect to the fetch stage. Taken and total branch counts are kept for performance debug.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- iValid  in  1  decode presents a branch
- oReady  out  1  controller can accept a branch (high only in IDLE)
- iOp  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 illegal (never taken)
- iPc  in  32  address of the branch instruction
- iImm  in  16  branch offset field
- iRs, iRt  in  32  operand values, signed compares use iRs only (except BEQ/BNE)
- iSlotDone  in  1  delay-slot instruction has issued
- iFlush  in  1  abort any in-flight branch
- oRedirValid  out  1  redirect request to fetch
- iRedirReady  in  1  fetch accepts redirect
- oRedirPc  out  32  redirect target, stable while oRedirValid
- oTaken  out  1  registered condition result of last evaluated branch
- oBusy  out  1  state != IDLE
- oBrCnt, oTakenCnt  out  16  saturating counters of evaluated / taken branches

## Operation
- States: IDLE, EVAL, DSLOT, REDIR.
- IDLE: oReady=1. If iValid && !iFlush, latch iOp, iPc, iImm, iRs, iRt, then go to EVAL. iFlush takes priority, so the branch is not accepted.
- EVAL: compute the condition and the target.
  - Target = iPc + 32'd4 + {{14{iImm[15]}}, iImm, 2'b00}, modulo 2^32 (wrap, no overflow flag).
  - Register oTaken and oRedirPc.
  - Increment oBrCnt. Increment oTakenCnt if taken. Both saturate at 0xFFFF.
  - Taken: go to DSLOT. Not taken: go to IDLE.
- DSLOT: wait for iSlotDone. When iSlotDone=1, go to REDIR next cycle. A iSlotDone pulse that arrives before DSLOT is ignored.
- REDIR: oRedirValid=1 and oRedirPc held stable. On iRedirReady=1 the transfer completes and the FSM goes to IDLE.
- Conditions: BLEZ rs<=0, BGTZ rs>0, BLTZ rs<0, BGEZ rs>=0, all signed 32-bit.
- iFlush in EVAL/DSLOT/REDIR: next state IDLE. No redirect is issued, even if iRedirReady is high in the same cycle (flush wins). Counters keep any increment already made in EVAL. A flush in EVAL suppresses that cycle's counter update.
- rst (any state, mid-operation): state=IDLE, oTaken=0, oRedirValid=0, oRedirPc=0, oBrCnt=0, oTakenCnt=0. oReady=1 and oBusy=0 from the first cycle after reset.

## Timing
- Accept at edge N (iValid && oReady). EVAL occupies cycle N+1. oTaken, oRedirPc and counters are valid from cycle N+2.
- Not taken: oReady=1 again in cycle N+2 (2-cycle occupancy).
- Taken with iSlotDone already high in DSLOT: DSLOT in N+2, oRedirValid=1 in N+3. With iRedirReady=1, oReady=1 in N+4.
- oRedirValid must not drop and oRedirPc must not change until the handshake completes or a flush/reset occurs.
- Only one branch is in flight; iValid while busy is held off by oReady=0.

## Test plan
- BEQ iPc=0x00400000, iImm=0x0010, iRs=iRt=5, iSlotDone=1, iRedirReady=1 -> oTaken=1, oRedirPc=0x00400044, oRedirValid high exactly 1 cycle, oBrCnt=1, oTakenCnt=1.
- BNE iRs=iRt=7 -> oTaken=0, no oRedirValid, oReady back after 2 cycles. Negative offset BGEZ iRs=0, iPc=0x00001000, iImm=0xFFFF -> oRedirPc=0x00001000.
- Wrap: BGTZ iRs=1, iPc=0xFFFFFFFC, iImm=0x0001 -> oRedirPc=0x00000004.
- Backpressure: taken branch, iRedirReady low for 5 cycles -> oRedirValid and oRedirPc stable all 5 cycles, IDLE one cycle after ready rises. iSlotDone delayed 3 cycles -> REDIR entered the cycle after it rises.
- iFlush asserted in DSLOT, and separately in REDIR together with iRedirReady=1 -> no redirect completes, IDLE next cycle, oTakenCnt retains its EVAL increment.
- rst asserted in REDIR -> next cycle all outputs zero, oReady=1. Drive 65537 evaluated branches -> oBrCnt saturates at 0xFFFF.
